montgomery_reducer: RTL and testbench
=====================================

MONTGOMERY_REDUCER -- requirements
Module: montgomery_reducer

Interface
REQ-001 Parameter: WORD_W, 64, reduction word width; SHALL divide 256; iteration count ITERS = 256/WORD_W.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  T/N/N_PRIME valid; consumes the 512-bit multiplier product stream.
REQ-005 in_ready  output  1  reducer can accept an operand this cycle.
REQ-006 T  input  512  product to reduce; precondition T < N*2^256.
REQ-007 N  input  256  modulus; odd.
REQ-008 N_PRIME  input  WORD_W  -N^-1 mod 2^WORD_W.
REQ-009 R  output  256  result T*2^-256 mod N.
REQ-010 out_valid  output  1  R valid.
REQ-011 out_ready  input  1  downstream accepts R.

Function
REQ-012 Input handshake SHALL occur on an edge where in_valid and in_ready are both 1; T, N and N_PRIME SHALL be captured in that edge.
REQ-013 States SHALL be IDLE, ITER, SUB, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE->ITER on input handshake; iteration counter cleared to 0.
REQ-015 Each ITER edge: m = (acc[WORD_W-1:0]*N_PRIME) mod 2^WORD_W; acc = (acc + m*N) >> WORD_W; counter += 1; acc SHALL be 513 bits wide, with no truncation before the shift.
REQ-016 ITER->SUB after ITERS iterations (counter = ITERS-1 on the edge).
REQ-017 SUB: R = acc - N if acc >= N, else acc[255:0]; out_valid set; ->DONE; out_valid SHALL rise exactly ITERS+1 edges after the accepting edge (5 for WORD_W=64).
REQ-018 DONE: R and out_valid held stable while out_ready=0; on an edge with out_ready=1, out_valid cleared, ->IDLE.
REQ-019 in_valid in any non-IDLE state SHALL be ignored; no operand queued.
REQ-020 Operand registers SHALL NOT change outside the accepting edge.
REQ-021 Result for an in-range T (REQ-006) SHALL lie in [0, N).

Reset
REQ-022 While reset=0 at an edge: state=IDLE, counter=0, out_valid=0, R=0, acc=0; in_ready=1 from the first edge after reset is released.
REQ-023 Reset asserted mid-ITER/SUB/DONE SHALL abandon the operation; no out_valid SHALL follow for it.

Configuration
REQ-024 Macro REDUCER_FINAL_SUB_EN defined: SUB state present, behaviour per REQ-017.
REQ-025 Macro undefined: SUB omitted; ITER->DONE with R = acc[255:0], latency ITERS edges; R in [0, 2N); caller SHALL guarantee N < 2^255.

Structure
REQ-026 Package modmul_pkg SHALL hold OPERAND_W=256, PRODUCT_W=512, the default WORD_W, and the state enum typedef, shared with the multiplier.
REQ-027 One sub-module redc_step (combinational single iteration: acc, N, N_PRIME in; next acc out) SHALL be instantiated once and reused across all iterations.

Verification (N = 2^255-19, N_PRIME computed by the bench golden model, WORD_W=64)
REQ-028 T=0 -> R=0, out_valid high exactly 5 edges after acceptance (4 with macro undefined).
REQ-029 T=2^256 -> R=1; T=(N-1)*2^256 -> R=N-1.
REQ-030 Random T < N*2^256 (1000 vectors) -> R equals golden T*2^-256 mod N; without the macro, R mod N matches the golden value and R < 2N.
REQ-031 out_ready held 0 for 10 cycles after out_valid -> R and out_valid stable, in_ready=0, a second in_valid pulse ignored; R consumed on the first out_ready=1 edge, in_ready=1 on the next cycle.
REQ-032 reset=0 for one cycle during the 2nd iteration -> out_valid stays 0, in_ready=1 after release; the next operand T=2^256 yields R=1.

Source files
------------

// File: rtl/modmul_pkg.sv
// modmul_pkg: operand/product widths, default reduction word width and the
// reducer state encoding, shared by the Montgomery multiplier datapath.
package modmul_pkg;

  localparam int OPERAND_W  = 256;
  localparam int PRODUCT_W  = 512;
  // Accumulator carries one extra bit so acc + m*N never wraps before the shift.
  localparam int ACC_W      = PRODUCT_W + 1;
  localparam int DEF_WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } redc_state_e;

endpackage

// File: rtl/redc_step.sv
// redc_step: one combinational word-serial Montgomery reduction step.
//   m     = (acc mod 2^WORD_W) * N' mod 2^WORD_W
//   acc_o = (acc + m*N) >> WORD_W   (low word of the sum is zero by choice of m)
module redc_step
  import modmul_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic [ACC_W-1:0]     acc_i,
  input  logic [OPERAND_W-1:0] n_i,
  input  logic [WORD_W-1:0]    n_prime_i,
  output logic [ACC_W-1:0]     acc_o
);

  localparam int MN_W = OPERAND_W + WORD_W;

  logic [WORD_W-1:0] m;
  logic [MN_W-1:0]   mn;
  logic [ACC_W-1:0]  sum;

  // Full-width add before the shift; the 513-bit sum cannot overflow for T < N*2^256.
  always_comb begin
    m     = acc_i[WORD_W-1:0] * n_prime_i;
    mn    = MN_W'(m) * MN_W'(n_i);
    sum   = acc_i + ACC_W'(mn);
    acc_o = sum >> WORD_W;
  end

endmodule

// File: rtl/montgomery_reducer.sv
// montgomery_reducer: iterative Montgomery reduction, R = T * 2^-256 mod N.
// One redc_step instance is reused for ITERS = 256/WORD_W cycles (WORD_W must
// divide 256). Optional macro REDUCER_FINAL_SUB_EN adds the SUB state that
// brings the result into [0, N); without it R lies in [0, 2N) and the caller
// must keep N < 2^255.
module montgomery_reducer
  import modmul_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRODUCT_W-1:0] T,
  input  logic [OPERAND_W-1:0] N,
  input  logic [WORD_W-1:0]    N_PRIME,
  output logic [OPERAND_W-1:0] R,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int ITERS = OPERAND_W / WORD_W;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  redc_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [OPERAND_W-1:0]  n_q, n_d;
  logic [WORD_W-1:0]     np_q, np_d;
  logic [OPERAND_W-1:0]  r_q, r_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACC_W-1:0]      acc_nxt;

  redc_step #(.WORD_W(WORD_W)) u_step (
    .acc_i     (acc_q),
    .n_i       (n_q),
    .n_prime_i (np_q),
    .acc_o     (acc_nxt)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign R         = r_q;

  // Next-state: accept in IDLE, iterate, optionally subtract, then hold until consumed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    n_d         = n_q;
    np_d        = np_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = {1'b0, T};
          n_d     = N;
          np_d    = N_PRIME;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef REDUCER_FINAL_SUB_EN
          state_d = SUB;
`else
          r_d         = acc_nxt[OPERAND_W-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
`endif
        end
      end
`ifdef REDUCER_FINAL_SUB_EN
      SUB: begin
        // acc < 2N here, so a single subtraction lands in [0, N); the low 256
        // bits of the difference are exact because the true result is < N.
        if (acc_q >= {{(ACC_W-OPERAND_W){1'b0}}, n_q})
          r_d = acc_q[OPERAND_W-1:0] - n_q;
        else
          r_d = acc_q[OPERAND_W-1:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and accumulator state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand registers only change on the accepting edge.
  always_ff @(posedge clock) begin
    n_q  <= n_d;
    np_q <= np_d;
  end

endmodule

// File: tb/tb_montgomery_reducer.sv
// tb_montgomery_reducer: directed and constructed-random checks of the reducer
// with N = 2^255-19, WORD_W = 64.
module tb_montgomery_reducer;

`ifdef REDUCER_FINAL_SUB_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 4;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] T = '0;
  logic [255:0] N = '0;
  logic [63:0]  N_PRIME = '0;
  logic [255:0] R;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  montgomery_reducer #(.WORD_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .T         (T),
    .N         (N),
    .N_PRIME   (N_PRIME),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result check; without the final subtraction R only needs to be congruent and < 2N.
  task automatic chk_r(input string tag, input logic [255:0] got, input logic [255:0] exp);
`ifdef REDUCER_FINAL_SUB_EN
    chk(tag, 512'(got), 512'(exp));
`else
    logic [256:0] two_n;
    two_n = {N, 1'b0};
    chk({tag, "_lt2n"}, 512'({1'b0, got} < two_n), 512'd1);
    chk(tag, 512'((got >= N) ? got - N : got), 512'(exp));
`endif
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send(input logic [511:0] t);
    @(negedge clock);
    in_valid = 1'b1;
    T        = t;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    do begin
      @(posedge clock);
      #1 lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) chk({tag, "_timeout"}, 512'(out_valid), 512'd1);
  endtask

  task automatic consume();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [511:0] t, input logic [255:0] exp,
                        input bit chk_lat);
    int lat;
    send(t);
    wait_out(tag, lat);
    if (chk_lat) chk({tag, "_lat"}, 512'(lat), 512'(EXP_LAT));
    chk_r(tag, R, exp);
    consume();
    if (chk_lat) begin
      chk({tag, "_ov_clr"}, 512'(out_valid), 512'd0);
      chk({tag, "_rdy"}, 512'(in_ready), 512'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  inv;
    logic [767:0] x, d, t;
    logic [255:0] r_hold;
    int           lat;
    bit           seen;

    N = (256'd1 << 255) - 256'd19;
    // N' = -N^-1 mod 2^64 by Newton iteration on the low word.
    inv = N[63:0];
    for (int k = 0; k < 6; k++) inv = inv * (64'd2 - N[63:0] * inv);
    N_PRIME = -inv;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ov", 512'(out_valid), 512'd0);
    chk("rst_r", 512'(R), 512'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 chk("rst_rdy", 512'(in_ready), 512'd1);

    // Directed vectors
    run_op("t_zero", 512'd0, 256'd0, 1'b1);
    run_op("t_2p256", {256'd1, 256'd0}, 256'd1, 1'b1);
    run_op("t_nm1", {N - 256'd1, 256'd0}, N - 256'd1, 1'b1);
    run_op("t_5", {256'd5, 256'd0}, 256'd5, 1'b0);
    run_op("t_n", {256'd0, N}, 256'd0, 1'b0);
    run_op("t_n_7", {256'd7, N}, 256'd7, 1'b0);

    // Constructed random: T = X*2^256 - d*N with d <= 2X gives 0 <= T < N*2^256, result X
    for (int i = 0; i < 1000; i++) begin
      x = 768'(rnd256()) % 768'(N);
      d = 768'(rnd256()) % (2 * x + 768'd1);
      t = (x << 256) - d * 768'(N);
      run_op($sformatf("rand%0d", i), t[511:0], x[255:0], 1'b0);
    end

    // Backpressure: result held, input ignored while DONE
    send({256'd9, 256'd0});
    wait_out("bp", lat);
    chk("bp_lat", 512'(lat), 512'(EXP_LAT));
    chk_r("bp_r", R, 256'd9);
    r_hold = R;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      in_valid = (c == 3);
      T        = {256'd11, 256'd0};
      @(posedge clock);
      #1;
      chk("bp_hold_r", 512'(R), 512'(r_hold));
      chk("bp_hold_ov", 512'(out_valid), 512'd1);
      chk("bp_hold_rdy", 512'(in_ready), 512'd0);
    end
    in_valid = 1'b0;
    consume();
    chk("bp_ov_clr", 512'(out_valid), 512'd0);
    chk("bp_rdy", 512'(in_ready), 512'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("bp_no_queue", 512'(seen), 512'd0);

    // Reset pulse during the 2nd iteration abandons the operation
    send({256'd3, 256'd0});
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clock);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("rst_abandon", 512'(seen), 512'd0);
    chk("rst_mid_rdy", 512'(in_ready), 512'd1);
    run_op("after_rst", {256'd1, 256'd0}, 256'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
